// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: valid/ready operand and result channels of the barrel shifter
interface pipelined_barrel_shifter_if #(parameter int N = 8);
   localparam int SW = $clog2(N);
   logic          up_vld;
   logic          up_rdy;
   logic [N-1:0]  up_data;
   logic [SW-1:0] up_shamt;
   logic          up_dir;
   logic          up_arith;
   logic          down_vld;
   logic          down_rdy;
   logic [N-1:0]  down_data;
   modport master (
      output up_vld, up_data, up_shamt, up_dir, up_arith, down_rdy,
      input  up_rdy, down_vld, down_data
   );
   modport slave (
      input  up_vld, up_data, up_shamt, up_dir, up_arith, down_rdy,
      output up_rdy, down_vld, down_data
   );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(N)-stage left/logical-right/arithmetic-right shifter with valid/ready and bubble collapsing
module pipelined_barrel_shifter #(
   parameter int N = 8
) (
   input logic                       clk,
   input logic                       rst,
   pipelined_barrel_shifter_if.slave bus
);
   localparam int SW = $clog2(N);
   logic [SW-1:0]          vld_q, vld_d, dir_q, dir_d, fill_q, fill_d;
   logic [SW-1:0][N-1:0]   data_q, data_d;
   logic [SW-1:0][SW-1:0]  shamt_q, shamt_d;
   logic [SW-1:0]          rdy;
   logic [SW-1:0]          in_vld, in_dir, in_fill;
   logic [SW-1:0][N-1:0]   in_data, sh;
   logic [SW-1:0][SW-1:0]  in_shamt;
   logic                   unused_meta;
   // a stage can load unless it and every stage after it are full and the output is stalled
   for (genvar k = 0; k < SW; k++) begin : g_rdy
      assign rdy[k] = bus.down_rdy || !(&vld_q[SW-1:k]);
   end
   always_comb begin
      in_vld[0]   = bus.up_vld;
      in_data[0]  = bus.up_data;
      in_shamt[0] = bus.up_shamt;
      in_dir[0]   = bus.up_dir;
      in_fill[0]  = bus.up_dir && bus.up_arith && bus.up_data[N-1];
      for (int k = 1; k < SW; k++) begin
         in_vld[k]   = vld_q[k-1];
         in_data[k]  = data_q[k-1];
         in_shamt[k] = shamt_q[k-1];
         in_dir[k]   = dir_q[k-1];
         in_fill[k]  = fill_q[k-1];
      end
      for (int k = 0; k < SW; k++) begin
         sh[k] = !in_shamt[k][k] ? in_data[k] :
                 !in_dir[k]      ? in_data[k] << (1 << k) :
                 (in_data[k] >> (1 << k)) | (in_fill[k] ? ~({N{1'b1}} >> (1 << k)) : '0);
         vld_d[k]   = rdy[k] ? in_vld[k]   : vld_q[k];
         data_d[k]  = rdy[k] ? sh[k]       : data_q[k];
         shamt_d[k] = rdy[k] ? in_shamt[k] : shamt_q[k];
         dir_d[k]   = rdy[k] ? in_dir[k]   : dir_q[k];
         fill_d[k]  = rdy[k] ? in_fill[k]  : fill_q[k];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         data_q  <= '0;
         shamt_q <= '0;
         dir_q   <= '0;
         fill_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
      end
   end
   // control carried into the last stage has no further consumer
   assign unused_meta   = ^{shamt_q, dir_q[SW-1], fill_q[SW-1]};
   assign bus.up_rdy    = rdy[0];
   assign bus.down_vld  = vld_q[SW-1];
   assign bus.down_data = data_q[SW-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed self-checking bench for the pipelined barrel shifter
module tb_pipelined_barrel_shifter;
   localparam int N = 8;
   localparam logic [7:0] S_D   [5] = '{8'hB5, 8'hB5, 8'hB5, 8'h80, 8'h5A};
   localparam logic [2:0] S_SH  [5] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd0};
   localparam logic       S_DIR [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic       S_AR  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic [7:0] S_EXP [5] = '{8'h16, 8'hF6, 8'hA8, 8'hFF, 8'h5A};
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   pipelined_barrel_shifter_if #(.N(N)) bus ();
   pipelined_barrel_shifter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic dir, input logic ar);
      bus.up_vld   = v;
      bus.up_data  = d;
      bus.up_shamt = s;
      bus.up_dir   = dir;
      bus.up_arith = ar;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.down_rdy = 1'b1;
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.down_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b expected 0", bus.down_vld); end
      checks++; if (bus.down_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", bus.down_data); end
      checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL reset_up_rdy got %b expected 1", bus.up_rdy); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.down_vld !== 1'b0) begin errors++; $display("FAIL idle_vld got %b expected 0", bus.down_vld); end
      checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL idle_up_rdy got %b expected 1", bus.up_rdy); end
      @(posedge clk); #1;
   endtask
   task automatic test_single();
      bus.down_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, S_D[i], S_SH[i], S_DIR[i], S_AR[i]);
         @(negedge clk);
         checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL single%0d_up_rdy got %b expected 1", i, bus.up_rdy); end
         @(posedge clk); #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.down_vld !== (c == 3)) begin errors++; $display("FAIL single%0d_vld_cycle%0d got %b expected %b", i, c, bus.down_vld, c == 3); end
            if (c == 3) begin
               checks++;
               if (bus.down_data !== S_EXP[i]) begin errors++; $display("FAIL single%0d_data got %h expected %h", i, bus.down_data, S_EXP[i]); end
            end
            @(posedge clk); #1;
         end
      end
   endtask
   task automatic test_back_to_back();
      logic exp_v;
      logic [7:0] exp_d;
      bus.down_rdy = 1'b1;
      drive(1'b1, 8'h01, 3'd1, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         exp_v = (c >= 3) && (c <= 10);
         exp_d = 8'(2 * (c - 2));
         checks++; if (bus.down_vld !== exp_v) begin errors++; $display("FAIL stream_vld_cycle%0d got %b expected %b", c, bus.down_vld, exp_v); end
         if (exp_v) begin
            checks++; if (bus.down_data !== exp_d) begin errors++; $display("FAIL stream_data_cycle%0d got %h expected %h", c, bus.down_data, exp_d); end
         end
         checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL stream_up_rdy_cycle%0d got %b expected 1", c, bus.up_rdy); end
         @(posedge clk); #1;
         if (c + 1 < 8) drive(1'b1, 8'(c + 2), 3'd1, 1'b0, 1'b0);
         else drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      end
   endtask
   task automatic test_backpressure();
      int sent = 0;
      int rcv = 0;
      int cyc = 0;
      logic r;
      bus.down_rdy = 1'b0;
      drive(1'b1, 8'h11, 3'd2, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         r = bus.up_rdy;
         if (bus.down_vld) begin
            checks++; if (bus.down_data !== 8'h44) begin errors++; $display("FAIL bp_hold_cycle%0d got %h expected 44", c, bus.down_data); end
         end
         @(posedge clk); #1;
         if (r) sent++;
         drive(1'b1, 8'(8'h11 + sent), 3'd2, 1'b0, 1'b0);
      end
      @(negedge clk);
      checks++; if (sent !== 3) begin errors++; $display("FAIL bp_accepted got %0d expected 3", sent); end
      checks++; if (bus.up_rdy !== 1'b0) begin errors++; $display("FAIL bp_up_rdy_full got %b expected 0", bus.up_rdy); end
      checks++; if (bus.down_vld !== 1'b1) begin errors++; $display("FAIL bp_vld_full got %b expected 1", bus.down_vld); end
      @(posedge clk); #1 bus.down_rdy = 1'b1;
      while (rcv < 5 && cyc < 20) begin
         @(negedge clk);
         r = bus.up_rdy;
         if (cyc == 0) begin
            checks++; if (r !== 1'b1) begin errors++; $display("FAIL bp_release_up_rdy got %b expected 1", r); end
         end
         if (bus.down_vld) begin
            checks++;
            if (bus.down_data !== 8'(8'h44 + 4 * rcv)) begin errors++; $display("FAIL bp_drain%0d got %h expected %h", rcv, bus.down_data, 8'(8'h44 + 4 * rcv)); end
            rcv++;
         end
         @(posedge clk); #1;
         if (r && bus.up_vld) sent++;
         if (sent < 5) drive(1'b1, 8'(8'h11 + sent), 3'd2, 1'b0, 1'b0);
         else drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
         cyc++;
      end
      checks++; if (rcv !== 5) begin errors++; $display("FAIL bp_received got %0d expected 5", rcv); end
      checks++; if (sent !== 5) begin errors++; $display("FAIL bp_sent got %0d expected 5", sent); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.down_vld !== 1'b0) begin errors++; $display("FAIL bp_duplicate_cycle%0d got %b expected 0", c, bus.down_vld); end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_bubble();
      int rcv = 0;
      int cyc = 0;
      bus.down_rdy = 1'b0;
      drive(1'b1, 8'h01, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL bubble_rdy_a got %b expected 1", bus.up_rdy); end
      @(posedge clk); #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge clk); #1 drive(1'b1, 8'h02, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL bubble_rdy_b got %b expected 1", bus.up_rdy); end
      @(posedge clk); #1 drive(1'b1, 8'h03, 3'd1, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL bubble_rdy_c got %b expected 1", bus.up_rdy); end
      @(posedge clk); #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (bus.up_rdy !== 1'b0) begin errors++; $display("FAIL bubble_full_rdy got %b expected 0", bus.up_rdy); end
      checks++; if (bus.down_data !== 8'h02) begin errors++; $display("FAIL bubble_head got %h expected 02", bus.down_data); end
      @(posedge clk); #1 bus.down_rdy = 1'b1;
      while (rcv < 3 && cyc < 10) begin
         @(negedge clk);
         if (bus.down_vld) begin
            checks++;
            if (bus.down_data !== 8'(2 * (rcv + 1))) begin errors++; $display("FAIL bubble_drain%0d got %h expected %h", rcv, bus.down_data, 8'(2 * (rcv + 1))); end
            rcv++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (rcv !== 3) begin errors++; $display("FAIL bubble_received got %0d expected 3", rcv); end
   endtask
   task automatic test_reset_mid();
      int seen = 0;
      int cyc = 0;
      bus.down_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h21 + i), 3'd0, 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.down_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b expected 0", bus.down_vld); end
      checks++; if (bus.down_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h expected 00", bus.down_data); end
      checks++; if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_up_rdy got %b expected 1", bus.up_rdy); end
      @(posedge clk); #1 bus.down_rdy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++; if (bus.down_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stale_cycle%0d got %b expected 0", c, bus.down_vld); end
         @(posedge clk); #1;
      end
      drive(1'b1, 8'hB5, 3'd1, 1'b1, 1'b0);
      @(posedge clk); #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      while (seen == 0 && cyc < 10) begin
         @(negedge clk);
         if (bus.down_vld) begin
            seen = 1;
            checks++; if (bus.down_data !== 8'h5A) begin errors++; $display("FAIL rstmid_recover got %h expected 5a", bus.down_data); end
            checks++; if (cyc !== 2) begin errors++; $display("FAIL rstmid_latency got %0d expected 2", cyc); end
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (seen !== 1) begin errors++; $display("FAIL rstmid_no_result got %0d expected 1", seen); end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_bubble();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
